// File: rtl/counter_ctrl.sv
// counter_ctrl: prescaled up-counter with one-shot / auto-reload modes and
// start / stop (pause) / clear control.
//
// Ports:
//   clk       in   sole clock, rising edge
//   reset     in   synchronous, active-low reset
//   start     in   start from IDLE/DONE, resume from PAUSE
//   stop      in   pause while in RUN
//   clear     in   abort to IDLE from any state
//   mode      in   0 = one-shot, 1 = auto-reload (latched on start)
//   load_val  in   terminal count (latched on start)
//   prescale  in   divide ratio minus 1 (latched on start)
//   count     out  current count
//   state     out  IDLE=00, RUN=01, PAUSE=10, DONE=11
//   busy      out  high in RUN or PAUSE
//   tc_pulse  out  one-cycle pulse per terminal tick
//   done      out  high while in DONE
module counter_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t                state_q;
  logic [PRESCALE_W-1:0] pc;
  logic [PRESCALE_W-1:0] ps_reg;
  logic [WIDTH-1:0]      tc_reg;
  logic                  mode_reg;

  // FSM, prescaler and counter; priority reset > clear > stop > start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      pc       <= '0;
      tc_reg   <= '0;
      ps_reg   <= '0;
      mode_reg <= 1'b0;
      tc_pulse <= 1'b0;
    end else if (clear) begin
      state_q  <= ST_IDLE;
      count    <= '0;
      pc       <= '0;
      tc_pulse <= 1'b0;
    end else begin
      tc_pulse <= 1'b0;
      case (state_q)
        // stop is ignored in IDLE and DONE; start (re)latches configuration.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            tc_reg   <= load_val;
            ps_reg   <= prescale;
            mode_reg <= mode;
            count    <= '0;
            pc       <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            // Pause suppresses this cycle's tick; count and pc hold.
            state_q <= ST_PAUSE;
          end else if (pc == ps_reg) begin
            pc <= '0;
            if (count == tc_reg) begin
              tc_pulse <= 1'b1;
              if (mode_reg) begin
                count <= '0;
              end else begin
                state_q <= ST_DONE;
              end
            end else begin
              count <= count + WIDTH'(1);
            end
          end else begin
            pc <= pc + PRESCALE_W'(1);
          end
        end
        // Resume without re-latching; stop has no effect here.
        ST_PAUSE: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Status decodes straight off the state register.
  assign state = state_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: arithmetic reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_counter_ctrl;

  localparam int unsigned WIDTH      = 4;
  localparam int unsigned PRESCALE_W = 4;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  mode;
  logic [WIDTH-1:0]      load_val;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic [1:0]            state;
  logic                  busy;
  logic                  tc_pulse;
  logic                  done;

  int checks   = 0;
  int failures = 0;

  counter_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .mode     (mode),
    .load_val (load_val),
    .prescale (prescale),
    .count    (count),
    .state    (state),
    .busy     (busy),
    .tc_pulse (tc_pulse),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: counts unpaused RUN edges since the last start and
  // derives tick count / count value arithmetically from that.
  bit m_valid = 1'b0;
  int m_st    = 0;
  int m_n     = 0;
  int m_tc    = 0;
  int m_ps    = 0;
  int m_mode  = 0;
  bit m_pulse = 1'b0;

  always @(posedge clk) begin
    m_pulse = 1'b0;
    if (!reset) begin
      m_valid = 1'b1;
      m_st = 0; m_n = 0; m_tc = 0; m_ps = 0; m_mode = 0;
    end else if (clear) begin
      m_st = 0; m_n = 0;
    end else begin
      case (m_st)
        0, 3: if (start) begin
          m_tc = int'(load_val); m_ps = int'(prescale); m_mode = int'(mode);
          m_n = 0; m_st = 1;
        end
        1: if (stop) m_st = 2;
           else begin
             m_n++;
             if ((m_n % (m_ps + 1)) == 0 && ((m_n / (m_ps + 1)) % (m_tc + 1)) == 0) begin
               m_pulse = 1'b1;
               if (m_mode == 0) m_st = 3;
             end
           end
        2: if (start) m_st = 1;
        default: m_st = 0;
      endcase
    end
  end

  function automatic int exp_count();
    case (m_st)
      1, 2:    return (m_n / (m_ps + 1)) % (m_tc + 1);
      3:       return m_tc;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state", int'(state), m_st);
      check("model_count", int'(count), exp_count());
      check("model_busy", int'(busy), (m_st == 1 || m_st == 2) ? 1 : 0);
      check("model_done", int'(done), (m_st == 3) ? 1 : 0);
      check("model_tc_pulse", int'(tc_pulse), int'(m_pulse));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    mode = 1'b0; load_val = '0; prescale = '0;
    step(2);
    check("reset_state", int'(state), 0);
    check("reset_count", int'(count), 0);
    reset = 1'b1;

    // Auto-reload, terminal 3, no prescale.
    mode = 1'b1; load_val = 4'd3; prescale = 4'd0;
    pulse_start();
    check("ar_run_state", int'(state), 1);
    check("ar_busy", int'(busy), 1);
    step(3);
    check("ar_count3", int'(count), 3);
    step(1);
    check("ar_wrap_count", int'(count), 0);
    check("ar_wrap_pulse", int'(tc_pulse), 1);
    step(1);
    check("ar_pulse_low", int'(tc_pulse), 0);
    // Changing load_val mid-run must not move the wrap point.
    load_val = 4'd7;
    step(2);
    check("ar_count3_again", int'(count), 3);
    step(1);
    check("ar_wrap_still3", int'(tc_pulse), 1);
    check("ar_wrap_still3_count", int'(count), 0);

    // Reset held two cycles mid-RUN.
    step(1);
    reset = 1'b0;
    step(2);
    check("rst_run_state", int'(state), 0);
    check("rst_run_count", int'(count), 0);
    check("rst_run_busy", int'(busy), 0);
    check("rst_run_done", int'(done), 0);
    check("rst_run_pulse", int'(tc_pulse), 0);
    reset = 1'b1;

    // One-shot, terminal 2, prescale 1.
    mode = 1'b0; load_val = 4'd2; prescale = 4'd1;
    pulse_start();
    step(5);
    check("os_count_pre", int'(count), 2);
    check("os_state_pre", int'(state), 1);
    step(1);
    check("os_pulse", int'(tc_pulse), 1);
    check("os_state_done", int'(state), 3);
    check("os_done", int'(done), 1);
    check("os_count_hold", int'(count), 2);
    step(3);
    check("os_pulse_once", int'(tc_pulse), 0);
    check("os_count_hold2", int'(count), 2);

    // Start from DONE, pause at 5, resume.
    mode = 1'b1; load_val = 4'd9; prescale = 4'd0;
    pulse_start();
    check("re_count0", int'(count), 0);
    step(5);
    check("pz_count5", int'(count), 5);
    stop = 1'b1; step(1); stop = 1'b0;
    check("pz_state", int'(state), 2);
    step(4);
    check("pz_hold_state", int'(state), 2);
    check("pz_hold_count", int'(count), 5);
    pulse_start();
    check("pz_resume_state", int'(state), 1);
    step(1);
    check("pz_resume_count6", int'(count), 6);

    // Clear, then start+stop combinations.
    clear = 1'b1; step(1); clear = 1'b0;
    check("clr_state", int'(state), 0);
    stop = 1'b1; step(1);
    check("idle_stop_ignored", int'(state), 0);
    start = 1'b1; step(1);
    check("ss_idle_run", int'(state), 1);
    step(1);
    check("ss_run_pause", int'(state), 2);
    start = 1'b0; stop = 1'b0;
    clear = 1'b1; step(1); clear = 1'b0;
    check("clr_pause_state", int'(state), 0);
    check("clr_pause_count", int'(count), 0);

    // Terminal 0: pulse on every tick (period 3 with prescale 2).
    mode = 1'b1; load_val = 4'd0; prescale = 4'd2;
    pulse_start();
    step(3);
    check("tc0_pulse", int'(tc_pulse), 1);
    step(1);
    check("tc0_pulse_low", int'(tc_pulse), 0);
    step(8);
    clear = 1'b1; step(1); clear = 1'b0;
    check("tc0_clear_pulse", int'(tc_pulse), 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
